retire_unit: RTL and testbench

- Last pipeline stage; the other end of the fetch jump/result/tag protocol.
- Accepts executed instructions carrying a 4-bit tag and retires only those whose tag matches the unit's expected tag.
- Commits register writeback and issues the registered `jump` pulse plus the `result` address back to fetch.
- On each jump it advances its expected tag in lockstep with fetch, so wrong-path instructions already in flight are squashed.

---
 rtl/retire_unit.sv | 116 +++++++++++
 tb/tb_retire_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_unit.sv
// Retire stage: commits tag-matched instructions and redirects fetch on taken branches.
// Optional misaligned-target trap is enabled by defining RETIRE_MISALIGN_TRAP_EN.
module retire_unit #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        valid_in,
    input  logic [3:0]  tag_in,
    input  logic        is_branch,
    input  logic        taken_in,
    input  logic [31:0] target_in,
    input  logic        we_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] wb_data_in,
    output logic        jump,
    output logic [31:0] result,
    output logic        reg_we,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic [3:0]  curr_tag,
    output logic        trap
);

    localparam logic [0:0] StRun      = 1'b0;
    localparam logic [0:0] StRedirect = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        jump_q, jump_d;
    logic [31:0] result_q, result_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [31:0] reg_data_q, reg_data_d;
    logic [3:0]  tag_q, tag_d;
    logic        trap_d;
    logic        match;

    // REDIRECT swallows one cycle so fetch can update its tag alongside ours.
    assign match = ce & valid_in & (state_q == StRun) & (tag_in == tag_q);

    always_comb begin
        state_d    = StRun;
        jump_d     = 1'b0;
        reg_we_d   = 1'b0;
        trap_d     = 1'b0;
        result_d   = result_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        tag_d      = tag_q;
        if (match) begin
            reg_we_d   = we_in & (rd_in != 5'd0);
            reg_addr_d = rd_in;
            reg_data_d = wb_data_in;
            if (is_branch && taken_in) begin
                jump_d   = 1'b1;
                result_d = target_in;
                tag_d    = tag_q + 4'd1;
                state_d  = StRedirect;
`ifdef RETIRE_MISALIGN_TRAP_EN
                if (target_in[1:0] != 2'b00) begin
                    trap_d   = 1'b1;
                    result_d = TRAP_VECTOR;
                    reg_we_d = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            jump_q     <= 1'b0;
            result_q   <= 32'd0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= 5'd0;
            reg_data_q <= 32'd0;
            tag_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            jump_q     <= jump_d;
            result_q   <= result_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            tag_q      <= tag_d;
        end
    end

`ifdef RETIRE_MISALIGN_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign trap = trap_q;
`else
    logic unused_trap;
    assign unused_trap = trap_d ^ (^TRAP_VECTOR);
    assign trap        = 1'b0;
`endif

    assign jump     = jump_q;
    assign result   = result_q;
    assign reg_we   = reg_we_q;
    assign reg_addr = reg_addr_q;
    assign reg_data = reg_data_q;
    assign curr_tag = tag_q;

endmodule

// File: tb/tb_retire_unit.sv
// Directed self-checking bench for retire_unit; build with +define+RETIRE_MISALIGN_TRAP_EN
// to exercise the trap path.
module tb_retire_unit;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        valid_in;
    logic [3:0]  tag_in;
    logic        is_branch;
    logic        taken_in;
    logic [31:0] target_in;
    logic        we_in;
    logic [4:0]  rd_in;
    logic [31:0] wb_data_in;
    logic        jump;
    logic [31:0] result;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [3:0]  curr_tag;
    logic        trap;

    int checks = 0;
    int errors = 0;

    retire_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .valid_in   (valid_in),
        .tag_in     (tag_in),
        .is_branch  (is_branch),
        .taken_in   (taken_in),
        .target_in  (target_in),
        .we_in      (we_in),
        .rd_in      (rd_in),
        .wb_data_in (wb_data_in),
        .jump       (jump),
        .result     (result),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .curr_tag   (curr_tag),
        .trap       (trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [3:0] t, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic w, input logic [4:0] rd,
                         input logic [31:0] d);
        valid_in   = v;
        tag_in     = t;
        is_branch  = br;
        taken_in   = tk;
        target_in  = tgt;
        we_in      = w;
        rd_in      = rd;
        wb_data_in = d;
    endtask

    task automatic bubble();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ce = 1'b1;
        bubble();
        do_reset();
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL reset_jump: got %b expected 0", jump); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we: got %b expected 0", reg_we); end
        checks++; if (reg_addr !== 5'd0) begin errors++; $display("FAIL reset_reg_addr: got %0d expected 0", reg_addr); end
        checks++; if (reg_data !== 32'h0) begin errors++; $display("FAIL reset_reg_data: got %h expected 0", reg_data); end
        checks++; if (curr_tag !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0", curr_tag); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b expected 0", trap); end
    endtask

    task automatic test_writeback();
        drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL wb_we: got %b expected 1", reg_we); end
        checks++; if (reg_addr !== 5'd5) begin errors++; $display("FAIL wb_addr: got %0d expected 5", reg_addr); end
        checks++; if (reg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_data: got %h expected deadbeef", reg_data); end
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL wb_jump: got %b expected 0", jump); end
        checks++; if (curr_tag !== 4'h0) begin errors++; $display("FAIL wb_tag: got %h expected 0", curr_tag); end
        bubble();
        tick();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL bubble_we: got %b expected 0", reg_we); end
        checks++; if (reg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bubble_hold: got %h expected deadbeef", reg_data); end
    endtask

    task automatic test_branch_squash();
        drive(1'b1, 4'h0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 5'd0, 32'h0);
        tick();
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL br_jump: got %b expected 1", jump); end
        checks++; if (result !== 32'h40) begin errors++; $display("FAIL br_result: got %h expected 40", result); end
        checks++; if (curr_tag !== 4'h1) begin errors++; $display("FAIL br_tag: got %h expected 1", curr_tag); end
        // Matching the new tag, but arrives during REDIRECT and must be ignored.
        drive(1'b1, 4'h1, 1'b0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h1111);
        tick();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL redirect_we: got %b expected 0", reg_we); end
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL redirect_jump: got %b expected 0", jump); end
        drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h2222);
        tick();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL squash_we: got %b expected 0", reg_we); end
        checks++; if (curr_tag !== 4'h1) begin errors++; $display("FAIL squash_tag: got %h expected 1", curr_tag); end
        drive(1'b1, 4'h1, 1'b0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h3333);
        tick();
        checks++; if (reg_we !== 1'b1 || reg_data !== 32'h3333) begin errors++; $display("FAIL post_squash: got we=%b data=%h expected we=1 data=3333", reg_we, reg_data); end
    endtask

    task automatic test_tag_wrap();
        logic [3:0] t;
        logic [3:0] exp_tag;
        bubble();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            t = 4'(i);
            exp_tag = 4'(i + 1);
            drive(1'b1, t, 1'b1, 1'b1, 32'(i * 8), 1'b0, 5'd0, 32'h0);
            tick();
            checks++; if (jump !== 1'b1 || curr_tag !== exp_tag) begin errors++; $display("FAIL wrap_%0d: got jump=%b tag=%h expected jump=1 tag=%h", i, jump, curr_tag, exp_tag); end
            bubble();
            tick();
        end
        drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd7, 32'h7777);
        tick();
        checks++; if (reg_we !== 1'b1 || reg_addr !== 5'd7) begin errors++; $display("FAIL wrap_retire: got we=%b addr=%0d expected we=1 addr=7", reg_we, reg_addr); end
    endtask

    task automatic test_stall_x0();
        ce = 1'b0;
        drive(1'b1, 4'h0, 1'b1, 1'b1, 32'h80, 1'b1, 5'd9, 32'h9999);
        tick();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL stall_we: got %b expected 0", reg_we); end
        checks++; if (jump !== 1'b0 || curr_tag !== 4'h0) begin errors++; $display("FAIL stall_jump: got jump=%b tag=%h expected jump=0 tag=0", jump, curr_tag); end
        ce = 1'b1;
        drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd0, 32'h5555);
        tick();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b expected 0", reg_we); end
        drive(1'b1, 4'h0, 1'b1, 1'b0, 32'h80, 1'b0, 5'd0, 32'h0);
        tick();
        checks++; if (jump !== 1'b0 || curr_tag !== 4'h0) begin errors++; $display("FAIL not_taken: got jump=%b tag=%h expected jump=0 tag=0", jump, curr_tag); end
        // A stalled REDIRECT cycle still returns to RUN.
        drive(1'b1, 4'h0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 5'd0, 32'h0);
        tick();
        ce = 1'b0;
        bubble();
        tick();
        ce = 1'b1;
        drive(1'b1, 4'h1, 1'b0, 1'b0, 32'h0, 1'b1, 5'd10, 32'hAAAA);
        tick();
        checks++; if (reg_we !== 1'b1 || reg_addr !== 5'd10) begin errors++; $display("FAIL redirect_ce0: got we=%b addr=%0d expected we=1 addr=10", reg_we, reg_addr); end
    endtask

    task automatic test_reset_redirect();
        bubble();
        do_reset();
        // JAL-style: link write and jump in the same cycle.
        drive(1'b1, 4'h0, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 5'd1, 32'h0000_0104);
        tick();
        checks++; if (jump !== 1'b1 || reg_we !== 1'b1 || curr_tag !== 4'h1) begin errors++; $display("FAIL jal: got jump=%b we=%b tag=%h expected 1 1 1", jump, reg_we, curr_tag); end
        bubble();
        #1 reset = 1'b1;
        #1;
        checks++; if (jump !== 1'b0 || reg_we !== 1'b0 || curr_tag !== 4'h0) begin errors++; $display("FAIL async_reset: got jump=%b we=%b tag=%h expected 0 0 0", jump, reg_we, curr_tag); end
        tick();
        reset = 1'b0;
        drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd2, 32'h2020);
        tick();
        checks++; if (reg_we !== 1'b1 || reg_data !== 32'h2020) begin errors++; $display("FAIL after_reset: got we=%b data=%h expected we=1 data=2020", reg_we, reg_data); end
    endtask

    task automatic test_misalign();
        bubble();
        do_reset();
        drive(1'b1, 4'h0, 1'b1, 1'b1, 32'h0000_0042, 1'b1, 5'd4, 32'h4444);
        tick();
`ifdef RETIRE_MISALIGN_TRAP_EN
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL mis_trap: got %b expected 1", trap); end
        checks++; if (result !== 32'h100) begin errors++; $display("FAIL mis_result: got %h expected 100", result); end
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL mis_we: got %b expected 0", reg_we); end
`else
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL mis_trap: got %b expected 0", trap); end
        checks++; if (result !== 32'h42) begin errors++; $display("FAIL mis_result: got %h expected 42", result); end
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL mis_we: got %b expected 1", reg_we); end
`endif
        checks++; if (jump !== 1'b1 || curr_tag !== 4'h1) begin errors++; $display("FAIL mis_jump: got jump=%b tag=%h expected jump=1 tag=1", jump, curr_tag); end
        bubble();
        tick();
        checks++; if (trap !== 1'b0 || jump !== 1'b0) begin errors++; $display("FAIL mis_pulse: got trap=%b jump=%b expected 0 0", trap, jump); end
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        bubble();
        test_reset();
        test_writeback();
        test_branch_squash();
        test_tag_wrap();
        test_stall_x0();
        test_reset_redirect();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
